ps2_scan_receiver: RTL and testbench
====================================

PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 Parameter: TIMEOUT_CYC, 50000, number of idle clk cycles mid-frame before the frame is abandoned.
REQ-002 Port: clk  input  1  system clock; all state is updated on the rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: ps2_clk  input  1  keyboard clock; asynchronous to clk.
REQ-005 Port: ps2_data  input  1  keyboard data; asynchronous to clk.
REQ-006 Port: dig1  output  4  low nibble of the last accepted scan code; this is the right-hand hex character.
REQ-007 Port: dig2  output  4  high nibble of the last accepted scan code; this is the left-hand hex character.
REQ-008 Port: code_valid  output  1  one-cycle strobe marking a new dig1/dig2 value.
REQ-009 Port: is_break  output  1  set when the code was preceded by 0xF0 (key released); valid with code_valid.
REQ-010 Port: is_ext  output  1  set when the code was preceded by 0xE0; valid with code_valid.
REQ-011 Port: frame_err  output  1  one-cycle strobe for a bad stop bit, a bad parity or a timeout.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected on synchronized ps2_clk (previous 1, current 0).
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY and STOP, and every sample SHALL be taken only on a detected falling edge.
REQ-014 IDLE: a falling edge with data=0 SHALL go to DATA with bit count 0; a falling edge with data=1 SHALL be ignored and the FSM stays in IDLE.
REQ-015 DATA: the byte SHALL be shifted in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-016 PARITY: the FSM SHALL sample the parity bit and go to STOP.
REQ-017 STOP: the FSM SHALL sample the stop bit and go to IDLE on the same edge.
REQ-018 A frame SHALL be good when stop=1 and, if checked, the 9 bits (data plus parity) have odd parity; otherwise frame_err SHALL pulse and no code SHALL be emitted.
REQ-019 A good byte of 0xF0 SHALL set the pending-break flag and a good byte of 0xE0 SHALL set the pending-ext flag; neither byte SHALL raise code_valid.
REQ-020 Any other good byte SHALL drive dig2=byte[7:4], dig1=byte[3:0], is_break=pending-break and is_ext=pending-ext.
REQ-021 On that byte, code_valid SHALL pulse high for exactly 1 clk, and both pending flags SHALL clear in the same cycle.
REQ-022 Latency: code_valid SHALL assert on the clk edge immediately after the cycle in which the stop-bit falling edge is detected.
REQ-023 dig1, dig2, is_break and is_ext SHALL hold their values until the next code_valid.
REQ-024 The pending flags SHALL survive a frame_err and SHALL be cleared only by an emitted code or by reset.
REQ-025 Timeout: in any state other than IDLE, TIMEOUT_CYC consecutive clk cycles with no falling edge SHALL force IDLE, pulse frame_err and discard the partial byte.
REQ-026 The timeout counter SHALL reset on every falling edge and on entry to IDLE, and SHALL saturate rather than wrap.
REQ-027 A falling edge in the same cycle that the timeout expires SHALL lose to the timeout; that edge SHALL NOT be treated as a start bit.

Reset
REQ-028 While rst_n=0, the FSM SHALL be IDLE and all counters, the shift register and the pending flags SHALL be 0.
REQ-029 While rst_n=0, dig1=0, dig2=0, code_valid=0, is_break=0, is_ext=0, frame_err=0 and the synchronizer flops SHALL be 1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no strobe; after release, the first falling edge with data=0 SHALL start a new frame.

Configuration
REQ-031 With PS2_PARITY_CHECK_EN defined, a parity mismatch SHALL suppress the code and pulse frame_err.
REQ-032 With PS2_PARITY_CHECK_EN undefined, the parity bit SHALL be sampled and ignored, and only the stop bit and timeout SHALL produce frame_err.

Structure
REQ-033 Package ps2_pkg SHALL hold the FSM state enum, PS2_BREAK=8'hF0, PS2_EXT=8'hE0 and the default TIMEOUT_CYC.
REQ-034 One sub-module, ps2_edge_sync, SHALL contain the synchronizers and falling-edge detector, and SHALL output ps2_fall and ps2_data_s.

Verification
REQ-035 Frame 0x1C with good parity -> one code_valid pulse with dig2=1, dig1=12, is_break=0 and is_ext=0; outputs hold afterwards.
REQ-036 Frames 0xF0 then 0x1C -> no strobe after 0xF0, one strobe after 0x1C with is_break=1, and is_break=0 on the next plain code.
REQ-037 Frames 0xE0, 0xF0 then 0x75 -> a single strobe with dig2=7, dig1=5, is_ext=1 and is_break=1.
REQ-038 Frame 0x24 with parity flipped, macro defined -> frame_err pulse and no code_valid; same stimulus with macro undefined -> code_valid with dig2=2, dig1=4.
REQ-039 Start bit plus 3 data bits, then silence for TIMEOUT_CYC+2 cycles -> one frame_err, FSM in IDLE; a following frame 0x3B -> dig2=3, dig1=11.
REQ-040 rst_n pulsed low after 5 bits of a frame -> no strobes; a full 0x15 frame after release -> dig2=1, dig1=5.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK       = 8'hF0;
  localparam logic [7:0] PS2_EXT         = 8'hE0;
  localparam int         PS2_TIMEOUT_CYC = 50000;

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizers for ps2_clk/ps2_data plus a falling-edge detector
// on the synchronized keyboard clock. Flops idle high like the PS/2 lines.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic ps2_fall,
  output logic ps2_data_s
);

  logic clk_p0, clk_p1, clk_p2;
  logic data_p0, data_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      clk_p2  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      // p0/p1: metastability stages; p2: previous synchronized clock
      clk_p0  <= ps2_clk;
      clk_p1  <= clk_p0;
      clk_p2  <= clk_p1;
      data_p0 <= ps2_data;
      data_p1 <= data_p0;
    end
  end

  assign ps2_fall   = clk_p2 & ~clk_p1;
  assign ps2_data_s = data_p1;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver producing scan-code hex digits with break/ext
// prefix flags. Define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_ext,
  output logic       frame_err
);

  localparam int             CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  ps2_state_e       state, state_nxt;
  logic             ps2_fall, ps2_data_s;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             par_q;
  logic [CNT_W-1:0] to_cnt;
  logic             pend_brk, pend_ext;
  logic             to_expire, edge_ok, frame_done, par_ok, frame_good;
  logic             got_byte, emit;

  ps2_edge_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_fall   (ps2_fall),
    .ps2_data_s (ps2_data_s)
  );

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  logic par_unused;
  assign par_unused = par_q;
  assign par_ok     = 1'b1;
`endif

  // Timeout wins over a coincident falling edge
  assign to_expire  = (state != IDLE) && (to_cnt == TO_LAST);
  assign edge_ok    = ps2_fall && !to_expire;
  assign frame_done = (state == STOP) && edge_ok;
  assign frame_good = ps2_data_s && par_ok;
  assign got_byte   = frame_done && frame_good;
  assign emit       = got_byte && (shift_q != PS2_BREAK) && (shift_q != PS2_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (to_expire) begin
      state_nxt = IDLE;
    end else if (ps2_fall) begin
      case (state)
        IDLE:    if (!ps2_data_s) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt     <= '0;
      pend_brk   <= 1'b0;
      pend_ext   <= 1'b0;
      dig1       <= '0;
      dig2       <= '0;
      is_break   <= 1'b0;
      is_ext     <= 1'b0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= emit;
      frame_err  <= (frame_done && !frame_good) || to_expire;

      if (state == IDLE || state_nxt == IDLE || ps2_fall) to_cnt <= '0;
      else if (to_cnt != TO_LAST)                         to_cnt <= to_cnt + 1'b1;

      if (edge_ok) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift_q <= {ps2_data_s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_q <= ps2_data_s;
          default: ;
        endcase
      end

      if (got_byte && shift_q == PS2_BREAK) pend_brk <= 1'b1;
      if (got_byte && shift_q == PS2_EXT)   pend_ext <= 1'b1;

      if (emit) begin
        dig2     <= shift_q[7:4];
        dig1     <= shift_q[3:0];
        is_break <= pend_brk;
        is_ext   <= pend_ext;
        pend_brk <= 1'b0;
        pend_ext <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver; honours PS2_PARITY_CHECK_EN.
module tb_ps2_scan_receiver;
  import ps2_pkg::*;

  localparam int TO = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] dig1, dig2;
  logic       code_valid, is_break, is_ext, frame_err;

  int checks = 0;
  int passes = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int cv_at  = 0;

  ps2_scan_receiver #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .dig1       (dig1),
    .dig2       (dig2),
    .code_valid (code_valid),
    .is_break   (is_break),
    .is_ext     (is_ext),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (code_valid) cv_cnt++;
    if (frame_err)  fe_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One PS/2 bit: data set, clock low for 10 cycles, high again.
  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (code_valid && cv_at == 0) cv_at = i;
    end
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
    cv_at = 0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip_par);
    ps2_bit(stop);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({dig2, dig1} !== 8'h00) $display("FAIL reset_digits got %h want 00", {dig2, dig1}); else passes++;
    checks++; if ({code_valid, is_break, is_ext, frame_err} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {code_valid, is_break, is_ext, frame_err}); else passes++;
    checks++; if (dut.state !== IDLE) $display("FAIL reset_state got %0d want %0d", dut.state, IDLE); else passes++;
    checks++; if ({dut.u_sync.clk_p0, dut.u_sync.clk_p1, dut.u_sync.data_p0, dut.u_sync.data_p1} !== 4'b1111)
      $display("FAIL reset_sync got %b want 1111",
               {dut.u_sync.clk_p0, dut.u_sync.clk_p1, dut.u_sync.data_p0, dut.u_sync.data_p1}); else passes++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic;
    int c0, f0;
    c0 = cv_cnt; f0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (cv_cnt - c0 !== 1) $display("FAIL basic_strobes got %0d want 1", cv_cnt - c0); else passes++;
    checks++; if (cv_at !== 3) $display("FAIL basic_latency got %0d want 3", cv_at); else passes++;
    checks++; if ({dig2, dig1} !== 8'h1C) $display("FAIL basic_digits got %h want 1c", {dig2, dig1}); else passes++;
    checks++; if ({is_break, is_ext} !== 2'b00) $display("FAIL basic_flags got %b want 00", {is_break, is_ext}); else passes++;
    checks++; if (fe_cnt - f0 !== 0) $display("FAIL basic_err got %0d want 0", fe_cnt - f0); else passes++;
    repeat (50) @(negedge clk);
    checks++; if ({dig2, dig1, cv_cnt - c0} !== {8'h1C, 32'd1})
      $display("FAIL basic_hold got %h/%0d want 1c/1", {dig2, dig1}, cv_cnt - c0); else passes++;
  endtask

  task automatic test_break;
    int c0;
    c0 = cv_cnt;
    send_frame(8'hF0, 1'b0, 1'b1);
    checks++; if (cv_cnt - c0 !== 0) $display("FAIL break_prefix_strobe got %0d want 0", cv_cnt - c0); else passes++;
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (cv_cnt - c0 !== 1) $display("FAIL break_strobes got %0d want 1", cv_cnt - c0); else passes++;
    checks++; if ({dig2, dig1, is_break, is_ext} !== {8'h1C, 2'b10})
      $display("FAIL break_code got %h %b want 1c 10", {dig2, dig1}, {is_break, is_ext}); else passes++;
    send_frame(8'h23, 1'b0, 1'b1);
    checks++; if ({dig2, dig1, is_break} !== {8'h23, 1'b0})
      $display("FAIL break_cleared got %h %b want 23 0", {dig2, dig1}, is_break); else passes++;
  endtask

  task automatic test_ext_break;
    int c0;
    c0 = cv_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    checks++; if (cv_cnt - c0 !== 1) $display("FAIL ext_strobes got %0d want 1", cv_cnt - c0); else passes++;
    checks++; if ({dig2, dig1, is_break, is_ext} !== {8'h75, 2'b11})
      $display("FAIL ext_code got %h %b want 75 11", {dig2, dig1}, {is_break, is_ext}); else passes++;
  endtask

  task automatic test_parity;
    int c0, f0;
    c0 = cv_cnt; f0 = fe_cnt;
    send_frame(8'h24, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    checks++; if (fe_cnt - f0 !== 1) $display("FAIL parity_err got %0d want 1", fe_cnt - f0); else passes++;
    checks++; if (cv_cnt - c0 !== 0) $display("FAIL parity_strobe got %0d want 0", cv_cnt - c0); else passes++;
    checks++; if ({dig2, dig1} !== 8'h75) $display("FAIL parity_hold got %h want 75", {dig2, dig1}); else passes++;
`else
    checks++; if (fe_cnt - f0 !== 0) $display("FAIL parity_err got %0d want 0", fe_cnt - f0); else passes++;
    checks++; if (cv_cnt - c0 !== 1) $display("FAIL parity_strobe got %0d want 1", cv_cnt - c0); else passes++;
    checks++; if ({dig2, dig1} !== 8'h24) $display("FAIL parity_code got %h want 24", {dig2, dig1}); else passes++;
`endif
  endtask

  task automatic test_stop_err;
    int c0, f0;
    send_frame(8'hF0, 1'b0, 1'b1);
    c0 = cv_cnt; f0 = fe_cnt;
    send_frame(8'h1B, 1'b0, 1'b0);
    checks++; if (fe_cnt - f0 !== 1) $display("FAIL stop_err got %0d want 1", fe_cnt - f0); else passes++;
    checks++; if (cv_cnt - c0 !== 0) $display("FAIL stop_strobe got %0d want 0", cv_cnt - c0); else passes++;
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if ({dig2, dig1, is_break} !== {8'h1C, 1'b1})
      $display("FAIL stop_pending got %h %b want 1c 1", {dig2, dig1}, is_break); else passes++;
  endtask

  task automatic test_timeout;
    int c0, f0;
    c0 = cv_cnt; f0 = fe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (TO + 2) @(negedge clk);
    checks++; if (fe_cnt - f0 !== 1) $display("FAIL timeout_err got %0d want 1", fe_cnt - f0); else passes++;
    checks++; if (dut.state !== IDLE) $display("FAIL timeout_state got %0d want %0d", dut.state, IDLE); else passes++;
    send_frame(8'h3B, 1'b0, 1'b1);
    checks++; if ({dig2, dig1, cv_cnt - c0} !== {8'h3B, 32'd1})
      $display("FAIL timeout_next got %h/%0d want 3b/1", {dig2, dig1}, cv_cnt - c0); else passes++;
  endtask

  task automatic test_reset_mid;
    int c0, f0;
    send_frame(8'hF0, 1'b0, 1'b1);
    c0 = cv_cnt; f0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({cv_cnt - c0, fe_cnt - f0} !== {32'd0, 32'd0})
      $display("FAIL rstmid_strobes got %0d/%0d want 0/0", cv_cnt - c0, fe_cnt - f0); else passes++;
    send_frame(8'h15, 1'b0, 1'b1);
    checks++; if ({dig2, dig1, is_break, is_ext} !== {8'h15, 2'b00})
      $display("FAIL rstmid_code got %h %b want 15 00", {dig2, dig1}, {is_break, is_ext}); else passes++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_break;
    test_ext_break;
    test_parity;
    test_stop_err;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
